// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: loads a W-bit pattern over valid/ready, then shifts
// len bits out MSB-first, reps times, with GAP idle cycles between repeats.
module seq_pattern_tx #(
  parameter int W   = 8,
  parameter int LW  = 4,
  parameter int CW  = 4,
  parameter int GAP = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [W-1:0]  pattern,
  input  logic [LW-1:0] len,
  input  logic [CW-1:0] reps,
  output logic          dout,
  output logic          dout_valid,
  output logic          last_bit,
  output logic          busy,
  output logic          done
);

  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [LW-1:0]  LEN_MAX  = LW'(W);
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   pat_q, pat_nxt;
  logic [LW-1:0]  len_q, len_nxt;
  logic [LW-1:0]  idx, idx_nxt;
  logic [CW-1:0]  rep_cnt, rep_nxt;
  logic [GCW-1:0] gap_cnt, gap_nxt;
  logic           dout_nxt, valid_nxt, last_nxt, done_nxt;
  logic [LW-1:0]  len_eff;
  logic [CW-1:0]  reps_eff;
  logic [W-1:0]   shifted;

  assign load_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);

  // Outputs are computed one cycle ahead so dout/dout_valid/last_bit line up
  // with the state: SEND cycles are exactly the cycles carrying a valid bit.
  always_comb begin
    len_eff   = (len > LEN_MAX) ? LEN_MAX : len;
    reps_eff  = (reps == '0) ? CW'(1) : reps;
    state_nxt = state;
    pat_nxt   = pat_q;
    len_nxt   = len_q;
    idx_nxt   = idx;
    rep_nxt   = rep_cnt;
    gap_nxt   = gap_cnt;
    valid_nxt = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_valid) begin
          pat_nxt = pattern;
          len_nxt = len_eff;
          rep_nxt = reps_eff - CW'(1);
          if (len_eff == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = ST_SEND;
            idx_nxt   = len_eff - LW'(1);
            valid_nxt = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (idx != '0) begin
          idx_nxt   = idx - LW'(1);
          valid_nxt = 1'b1;
        end else if (rep_cnt == '0) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          rep_nxt = rep_cnt - CW'(1);
          if (GAP > 0) begin
            state_nxt = ST_GAP;
            gap_nxt   = GAP_LAST;
          end else begin
            idx_nxt   = len_q - LW'(1);
            valid_nxt = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = ST_SEND;
          idx_nxt   = len_q - LW'(1);
          valid_nxt = 1'b1;
        end else begin
          gap_nxt = gap_cnt - GCW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    shifted  = pat_nxt >> idx_nxt;
    dout_nxt = valid_nxt & shifted[0];
    last_nxt = valid_nxt && (idx_nxt == '0) && (rep_nxt == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      pat_q      <= '0;
      len_q      <= '0;
      idx        <= '0;
      rep_cnt    <= '0;
      gap_cnt    <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      last_bit   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      pat_q      <= pat_nxt;
      len_q      <= len_nxt;
      idx        <= idx_nxt;
      rep_cnt    <= rep_nxt;
      gap_cnt    <= gap_nxt;
      dout       <= dout_nxt;
      dout_valid <= valid_nxt;
      last_bit   <= last_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: random and directed transfers compared
// cycle by cycle against a stream model built from the transfer rules.
module tb_seq_pattern_tx;
  localparam int W   = 8;
  localparam int LW  = 4;
  localparam int CW  = 4;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid, load_ready;
  logic [W-1:0]  pattern;
  logic [LW-1:0] len;
  logic [CW-1:0] reps;
  logic          dout, dout_valid, last_bit, busy, done;

  logic          load_valid0, load_ready0;
  logic [W-1:0]  pattern0;
  logic [LW-1:0] len0;
  logic [CW-1:0] reps0;
  logic          dout0, dout_valid0, last_bit0, busy0, done0;

  int n_cmp = 0;
  int n_err = 0;

  // expected per-cycle vector {dout, dout_valid, last_bit, busy, done, load_ready}
  logic [5:0] m_vec[$];

  always #5 clk = ~clk;

  seq_pattern_tx #(.W(W), .LW(LW), .CW(CW), .GAP(GAP)) u_dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .pattern(pattern), .len(len), .reps(reps), .dout(dout), .dout_valid(dout_valid),
    .last_bit(last_bit), .busy(busy), .done(done)
  );

  seq_pattern_tx #(.W(W), .LW(LW), .CW(CW), .GAP(0)) u_gap0 (
    .clk(clk), .reset(reset), .load_valid(load_valid0), .load_ready(load_ready0),
    .pattern(pattern0), .len(len0), .reps(reps0), .dout(dout0), .dout_valid(dout_valid0),
    .last_bit(last_bit0), .busy(busy0), .done(done0)
  );

  task automatic build_model(input logic [W-1:0] p_pat, input int p_len, input int p_reps,
                             input int p_gap);
    int l, r;
    logic [W-1:0] t;
    m_vec.delete();
    l = (p_len > W) ? W : p_len;
    r = (p_reps == 0) ? 1 : p_reps;
    if (l > 0) begin
      for (int k = 0; k < r; k++) begin
        for (int i = l - 1; i >= 0; i--) begin
          t = p_pat >> i;
          m_vec.push_back({t[0], 1'b1, (k == r - 1 && i == 0), 1'b1, 1'b0, 1'b0});
        end
        if (k < r - 1)
          for (int g = 0; g < p_gap; g++) m_vec.push_back(6'b000100);
      end
    end
    m_vec.push_back(6'b000011);
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge of the done cycle.
  task automatic xfer(input string name, input logic [W-1:0] p_pat, input logic [LW-1:0] p_len,
                      input logic [CW-1:0] p_reps, input bit noise);
    logic [5:0] act;
    build_model(p_pat, int'(p_len), int'(p_reps), GAP);
    n_cmp++;
    if (load_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_at_load: got %b want 1", name, load_ready);
    end
    load_valid = 1'b1; pattern = p_pat; len = p_len; reps = p_reps;
    for (int c = 0; c < m_vec.size(); c++) begin
      @(negedge clk);
      if (noise && c < m_vec.size() - 1) begin
        load_valid = 1'($urandom);
        pattern    = W'($urandom);
        len        = LW'($urandom);
        reps       = CW'($urandom);
      end else begin
        load_valid = 1'b0;
      end
      act = {dout, dout_valid, last_bit, busy, done, load_ready};
      n_cmp++;
      if (act !== m_vec[c]) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %b want %b (dout,valid,last,busy,done,ready)",
                 name, c, act, m_vec[c]);
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] act;
    reset = 1'b1;
    load_valid = 1'b1; pattern = 8'hFF; len = 4'd8; reps = 4'd1;
    repeat (2) @(negedge clk);
    act = {dout, dout_valid, last_bit, busy, done, load_ready};
    n_cmp++;
    if (act !== 6'b000001) begin
      n_err++;
      $display("FAIL reset_state: got %b want 000001", act);
    end
    reset = 1'b0; load_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      act = {dout, dout_valid, last_bit, busy, done, load_ready};
      n_cmp++;
      if (act !== 6'b000001) begin
        n_err++;
        $display("FAIL reset_load_ignored cycle %0d: got %b want 000001", c, act);
      end
    end
  endtask

  task automatic test_single();
    xfer("single", 8'b0000_1011, 4'd4, 4'd1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_repeat_gap();
    xfer("repeat_gap", 8'b0000_1011, 4'd4, 4'd2, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    xfer("b2b_first_busy_noise", 8'b0000_1011, 4'd4, 4'd2, 1'b1);
    xfer("b2b_second", 8'hA5, 4'd8, 4'd1, 1'b0);
    xfer("b2b_third", 8'h3C, 4'd6, 4'd2, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_boundaries();
    xfer("len0", 8'hFF, 4'd0, 4'd3, 1'b0);
    @(negedge clk);
    xfer("len12_clamp", 8'h96, 4'd12, 4'd1, 1'b0);
    @(negedge clk);
    xfer("reps0", 8'h5A, 4'd5, 4'd0, 1'b0);
    @(negedge clk);
    xfer("reps15_len1", 8'h01, 4'd1, 4'd15, 1'b0);
    xfer("reps15_len8", 8'hC3, 4'd8, 4'd15, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [5:0] act;
    build_model(8'hB7, 8, 1, GAP);
    load_valid = 1'b1; pattern = 8'hB7; len = 4'd8; reps = 4'd1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      load_valid = 1'b0;
      act = {dout, dout_valid, last_bit, busy, done, load_ready};
      n_cmp++;
      if (act !== m_vec[c]) begin
        n_err++;
        $display("FAIL reset_mid_prefix cycle %0d: got %b want %b", c, act, m_vec[c]);
      end
    end
    reset = 1'b1;
    #1;
    act = {dout, dout_valid, last_bit, busy, done, load_ready};
    n_cmp++;
    if (act !== 6'b000001) begin
      n_err++;
      $display("FAIL reset_mid_abort: got %b want 000001", act);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      act = {dout, dout_valid, last_bit, busy, done, load_ready};
      n_cmp++;
      if (act !== 6'b000001) begin
        n_err++;
        $display("FAIL reset_mid_no_done cycle %0d: got %b want 000001", c, act);
      end
    end
    xfer("after_reset", 8'h6D, 4'd8, 4'd1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_detector();
    logic [3:0] sh, msh;
    logic [5:0] act;
    int hits;
    build_model(8'b0000_1011, 4, 2, 0);
    sh = '0; msh = '0; hits = 0;
    load_valid0 = 1'b1; pattern0 = 8'b0000_1011; len0 = 4'd4; reps0 = 4'd2;
    for (int c = 0; c < m_vec.size(); c++) begin
      @(negedge clk);
      load_valid0 = 1'b0;
      act = {dout0, dout_valid0, last_bit0, busy0, done0, load_ready0};
      n_cmp++;
      if (act !== m_vec[c]) begin
        n_err++;
        $display("FAIL gap0_stream cycle %0d: got %b want %b", c, act, m_vec[c]);
      end
      sh  = {sh[2:0], dout0};
      msh = {msh[2:0], m_vec[c][5]};
      if (sh == 4'b1011) hits++;
      n_cmp++;
      if ((sh == 4'b1011) !== (msh == 4'b1011)) begin
        n_err++;
        $display("FAIL detector_hit cycle %0d: got %b want %b", c, sh == 4'b1011, msh == 4'b1011);
      end
    end
    n_cmp++;
    if (hits != 2) begin
      n_err++;
      $display("FAIL detector_hits: got %0d want 2", hits);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0]  p;
    logic [LW-1:0] l;
    logic [CW-1:0] r;
    for (int n = 0; n < 24; n++) begin
      p = W'($urandom);
      l = LW'($urandom_range(0, 15));
      r = CW'($urandom_range(0, 5));
      xfer($sformatf("random%0d", n), p, l, r, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    load_valid = 1'b0; pattern = '0; len = '0; reps = '0;
    load_valid0 = 1'b0; pattern0 = '0; len0 = '0; reps0 = '0;
    test_reset();
    test_single();
    test_repeat_gap();
    test_back_to_back();
    test_boundaries();
    test_reset_mid();
    test_detector();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
